// File: rtl/reg_reader_pkg.sv
// Shared register-index helpers for reg_reader and reg_writer.
// WIDTH/NUM come from the `WIDTH/`NUM macros, defaulting to 32 and 64.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef NUM
`define NUM 64
`endif

package reg_reader_pkg;
  localparam int WIDTH_DEF = `WIDTH;
  localparam int NUM_DEF   = `NUM;
  localparam int IDX_W     = 6;

  typedef logic [IDX_W-1:0] ridx_t;

  localparam ridx_t R0_IDX = '0;

  // Index layout: general registers 0..31, float registers 32..63.
  function automatic ridx_t reg_idx(input logic gf, input logic [4:0] num);
    return {gf, num};
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per register: set on reservation, cleared on writeback, set wins on collision.
// Queries are registered state only; r0 can never become busy.
module reg_scoreboard
  import reg_reader_pkg::*;
#(
  parameter int NUM = NUM_DEF
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  set_en_i,
  input  ridx_t set_idx_i,
  input  logic  clr_en_i,
  input  ridx_t clr_idx_i,
  input  ridx_t q1_idx_i,
  input  ridx_t q2_idx_i,
  input  ridx_t q3_idx_i,
  output logic  busy1_o,
  output logic  busy2_o,
  output logic  busy3_o
);

  logic [NUM-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i && (set_idx_i != R0_IDX)) busy_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy1_o = busy_q[q1_idx_i];
  assign busy2_o = busy_q[q2_idx_i];
  assign busy3_o = busy_q[q3_idx_i];

endmodule

// File: rtl/reg_reader.sv
// Operand read stage: two-source read with busy scoreboard, 1-cycle registered output.
// Optional REG_READER_BYPASS_EN forwards same-cycle writeback data instead of stalling.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef NUM
`define NUM 64
`endif

module reg_reader
  import reg_reader_pkg::*;
#(
  parameter int WIDTH = `WIDTH,
  parameter int NUM   = `NUM
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH*NUM-1:0] regsout,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 rs1_gf,
  input  logic [4:0]           rs1_num,
  input  logic                 rs2_gf,
  input  logic [4:0]           rs2_num,
  input  logic                 rd_gf,
  input  logic [4:0]           rd_num,
  input  logic                 rd_reserve,
  input  logic                 wb_gf,
  input  logic [4:0]           wb_num,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 wb_enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2
);

  ridx_t rs1_idx, rs2_idx, rd_idx, wb_idx;
  logic  busy1, busy2, busy_rd;
  logic  haz1, haz2, haz_rd, hazard, accept;
  logic  [WIDTH-1:0] op1, op2;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data1_q, data1_d, data2_q, data2_d;

  assign rs1_idx = reg_idx(rs1_gf, rs1_num);
  assign rs2_idx = reg_idx(rs2_gf, rs2_num);
  assign rd_idx  = reg_idx(rd_gf, rd_num);
  assign wb_idx  = reg_idx(wb_gf, wb_num);

  reg_scoreboard #(.NUM(NUM)) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .set_en_i  (accept && rd_reserve),
    .set_idx_i (rd_idx),
    .clr_en_i  (wb_enable),
    .clr_idx_i (wb_idx),
    .q1_idx_i  (rs1_idx),
    .q2_idx_i  (rs2_idx),
    .q3_idx_i  (rd_idx),
    .busy1_o   (busy1),
    .busy2_o   (busy2),
    .busy3_o   (busy_rd)
  );

  always_comb begin
    op1 = (rs1_idx == R0_IDX) ? '0 : regsout[int'(rs1_idx)*WIDTH +: WIDTH];
    op2 = (rs2_idx == R0_IDX) ? '0 : regsout[int'(rs2_idx)*WIDTH +: WIDTH];
`ifdef REG_READER_BYPASS_EN
    // The register file only takes wb_data at this edge, so forward it directly.
    haz1   = busy1 && !(wb_enable && (wb_idx == rs1_idx));
    haz2   = busy2 && !(wb_enable && (wb_idx == rs2_idx));
    haz_rd = rd_reserve && busy_rd && !(wb_enable && (wb_idx == rd_idx));
    if (wb_enable && (wb_idx == rs1_idx) && (rs1_idx != R0_IDX)) op1 = wb_data;
    if (wb_enable && (wb_idx == rs2_idx) && (rs2_idx != R0_IDX)) op2 = wb_data;
`else
    haz1   = busy1;
    haz2   = busy2;
    haz_rd = rd_reserve && busy_rd;
`endif
  end

`ifndef REG_READER_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign hazard    = haz1 || haz2 || haz_rd;
  assign req_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept    = req_valid && req_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data1_d     = op1;
      data2_d     = op2;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data1 = data1_q;
  assign out_data2 = data2_q;

endmodule
